// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between
// instruction fetch (if_*) and the data-memory stage (dm_*).
// Accesses go one at a time through IDLE -> CMD -> WAIT -> RESP. When both
// requesters are pending, the one that was not served last wins.
//
// State table:
//   IDLE | sample requests, grant one and latch the command registers
//   CMD  | mem_en high for this single cycle
//   WAIT | hold command registers until mem_done, capture read data
//   RESP | one-cycle done pulse to the owner; no arbitration here
//
// Ports:
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_rdata/if_done/if_stall        fetch side
//   dm_rd/dm_wr/dm_addr/dm_wdata -> dm_rdata/dm_done/dm_stall/dm_err
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata/mem_done   memory side
//   stall_cnt: saturating count of cycles with any requester stalled
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          dm_err,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} arbState;
  typedef enum logic {OWN_IF, OWN_DM} ownerSel;

  arbState state;
  ownerSel owner;
  ownerSel lastOwner;

  logic pendIf;
  logic pendDm;
  logic grantDm;
  logic anyStall;

  assign pendIf   = if_req;
  assign pendDm   = dm_rd | dm_wr;
  // DM wins when alone, or under contention when fetch was served last.
  assign grantDm  = pendDm & (~pendIf | (lastOwner == OWN_IF));
  assign if_stall = if_req & ~if_done;
  assign dm_stall = pendDm & ~dm_done;
  assign anyStall = if_stall | dm_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lastOwner <= OWN_IF;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (anyStall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (pendIf || pendDm) begin
            state  <= CMD;
            mem_en <= 1'b1;
            if (grantDm) begin
              owner     <= OWN_DM;
              lastOwner <= OWN_DM;
              mem_addr  <= dm_addr;
              // rd and wr together executes as a write and flags the error
              mem_wr    <= dm_wr;
              mem_wdata <= dm_wdata;
              if (dm_rd && dm_wr)
                dm_err <= 1'b1;
            end else begin
              owner     <= OWN_IF;
              lastOwner <= OWN_IF;
              mem_addr  <= if_addr;
              mem_wr    <= 1'b0;
            end
          end
        end
        CMD: begin
          // mem_done here is too early to be a real completion and is ignored
          mem_en <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (mem_done) begin
            if (!mem_wr) begin
              if (owner == OWN_DM)
                dm_rdata <= mem_rdata;
              else
                if_rdata <= mem_rdata;
            end
            if (owner == OWN_DM)
              dm_done <= 1'b1;
            else
              if_done <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if_done <= 1'b0;
          dm_done <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random requesters and a random-latency memory responder
// drive mem_arbiter; a cycle-timeline model (grant cycle, command cycle,
// completion cycle, free cycle) predicts every output each cycle.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_done, if_stall;
  logic          dm_rd = 1'b0, dm_wr = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_done, dm_stall, dm_err;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_done = 1'b0;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall), .dm_err(dm_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_cnt(stall_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // model state: a transaction is described by the cycles where things happen
  bit            busy;
  int            freeAt, enCycle, mdCycle, doneCycle;
  bit            expOwnerDm, lastDm, expErr, expWr;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expWdata, expRdataNext, expIfRdata, expDmRdata;
  int            expCnt;
  bit            ifActive, dmActive, responderOn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyReset();
    rst = 1'b0;
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; mem_done = 1'b0;
    #2;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_dm_err", dm_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    busy = 0; enCycle = -1; mdCycle = -1; doneCycle = -1;
    lastDm = 0; expErr = 0; expCnt = 0; expWr = 0;
    expIfRdata = '0; expDmRdata = '0; expOwnerDm = 0;
    ifActive = 0; dmActive = 0;
    freeAt = cyc + 1;
  endtask

  task automatic step(input bit agentsOn, input bit forceBoth, input bit forceSpur);
    int k;
    bit pIf, pDm, gDm, eIfStall, eDmStall;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == doneCycle && !expWr) begin
      if (expOwnerDm) expDmRdata = expRdataNext;
      else            expIfRdata = expRdataNext;
    end

    chk("mem_en", mem_en, (cyc == enCycle));
    if (busy && enCycle >= 0 && cyc >= enCycle && (mdCycle < 0 || cyc <= mdCycle)) begin
      chk("mem_addr", mem_addr, expAddr);
      chk("mem_wr", mem_wr, expWr);
      if (expOwnerDm && expWr) chk("mem_wdata", mem_wdata, expWdata);
    end
    chk("if_done", if_done, (cyc == doneCycle && !expOwnerDm));
    chk("dm_done", dm_done, (cyc == doneCycle && expOwnerDm));
    chk("if_rdata", if_rdata, expIfRdata);
    chk("dm_rdata", dm_rdata, expDmRdata);
    chk("dm_err", dm_err, expErr);
    chk("stall_cnt", stall_cnt, expCnt);

    if (cyc == doneCycle) begin
      busy = 0;
      freeAt = cyc + 1;
      if (expOwnerDm) dmActive = 0;
      else            ifActive = 0;
    end

    if (agentsOn) begin
      if (!ifActive && (forceBoth || $urandom_range(2) == 0)) begin
        ifActive = 1;
        if_addr = 16'($urandom);
      end
      if (!dmActive && (forceBoth || $urandom_range(2) == 0)) begin
        dmActive = 1;
        k = $urandom_range(7);
        dm_rd = (k < 3) || (k == 7);
        dm_wr = (k >= 3);
        dm_addr = 16'($urandom);
        dm_wdata = 16'($urandom);
      end
    end
    if_req = ifActive;
    if (!dmActive) begin dm_rd = 1'b0; dm_wr = 1'b0; end

    mem_rdata = 16'($urandom);
    mem_done = 1'b0;
    if (responderOn && cyc == mdCycle) begin
      mem_done = 1'b1;
      expRdataNext = mem_rdata;
      doneCycle = cyc + 1;
    end else if (forceSpur ||
                 (responderOn && (!busy || cyc == enCycle) && $urandom_range(7) == 0)) begin
      mem_done = 1'b1;
    end

    if (!busy && cyc >= freeAt) begin
      pIf = if_req;
      pDm = dm_rd | dm_wr;
      if (pIf || pDm) begin
        gDm = pDm && (!pIf || !lastDm);
        expOwnerDm = gDm;
        lastDm = gDm;
        expAddr = gDm ? dm_addr : if_addr;
        expWr = gDm ? dm_wr : 1'b0;
        if (gDm) expWdata = dm_wdata;
        if (gDm && dm_rd && dm_wr) expErr = 1;
        busy = 1;
        enCycle = cyc + 1;
        mdCycle = responderOn ? enCycle + $urandom_range(4, 1) : -1;
        doneCycle = -1;
      end
    end

    #1;
    eIfStall = if_req && !(cyc == doneCycle && !expOwnerDm);
    eDmStall = (dm_rd || dm_wr) && !(cyc == doneCycle && expOwnerDm);
    chk("if_stall", if_stall, eIfStall);
    chk("dm_stall", dm_stall, eDmStall);
    if ((eIfStall || eDmStall) && expCnt < 32'hFFFF) expCnt++;
  endtask

  initial begin
    bit found;
    busy = 0; enCycle = -1; mdCycle = -1; doneCycle = -1;
    responderOn = 1;
    #1;
    applyReset();

    // contention straight out of reset, then random traffic
    step(1, 1, 0);
    repeat (3000) step(1, 0, 0);

    // reset while waiting on the memory, then a late mem_done
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1, 0, 0);
      if (busy && enCycle >= 0 && cyc > enCycle && cyc + 1 < mdCycle) found = 1;
    end
    chk("reset_window_reached", found, 1);
    applyReset();
    step(0, 0, 1);
    repeat (5) step(0, 0, 0);
    repeat (200) step(1, 0, 0);

    // memory never answers: stall counter must saturate and hold
    applyReset();
    responderOn = 0;
    repeat (70000) step(1, 0, 0);
    chk("stall_cnt_saturated", stall_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares a single-ported, variable-latency memory between instruction fetch and the data-memory stage of the processor. It sits between the fetch and memory stages and the unified memory model. It sequences one access at a time through a command/wait/response FSM and arbitrates round-robin under contention. It also drives per-requester stall signals and a saturating stall-cycle counter for the performance log.

## Interface
- AW, 16: address width.
- DW, 16: data width.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_done.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched word; valid while if_done=1, held until next fetch completion.
- if_done  out  1  one-cycle completion pulse to fetch.
- if_stall  out  1  if_req & ~if_done.
- dm_rd  in  1  data read request; held until dm_done.
- dm_wr  in  1  data write request; held until dm_done.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid while dm_done=1, held until next data completion.
- dm_done  out  1  one-cycle completion pulse to memory stage.
- dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done.
- dm_err  out  1  sticky: dm_rd and dm_wr sampled high together at grant.
- mem_en  out  1  one-cycle command strobe to memory.
- mem_wr  out  1  1 = write, 0 = read; stable from CMD through WAIT.
- mem_addr  out  AW  registered address; stable from CMD through WAIT.
- mem_wdata  out  DW  registered write data; stable from CMD through WAIT.
- mem_rdata  in  DW  memory read data, valid with mem_done.
- mem_done  in  1  memory completion pulse, earliest one cycle after mem_en.
- stall_cnt  out  16  cycles with if_stall|dm_stall, saturating at 0xFFFF.

## Operation
- FSM states: IDLE, CMD, WAIT, RESP. Registers: owner (IF/DM) and last_owner (reset IF).
- IDLE: pending_if = if_req; pending_dm = dm_rd|dm_wr.
  - Neither pending: stay in IDLE.
  - Exactly one pending: grant it.
  - Both pending: grant the requester that is not last_owner.
  - On grant: latch owner, mem_addr, mem_wr, mem_wdata; update last_owner; go to CMD.
- IF grant: mem_wr=0.
- DM grant: mem_wr=dm_wr. If dm_rd&dm_wr, the access executes as a write and dm_err is set.
- CMD: mem_en=1 for exactly this cycle; go to WAIT unconditionally. mem_done in CMD is ignored.
- WAIT: hold the command registers. On mem_done, capture mem_rdata into the owner's rdata register (not for writes) and go to RESP.
- RESP: assert the owner's done for one cycle; go to IDLE. No grant in RESP, so a request still high while its done is asserted is never re-served.
- mem_done outside WAIT is ignored with no state change.
- dm_err clears only on reset. stall_cnt increments when if_stall|dm_stall and stops at 0xFFFF.

## Timing
- Reset (asynchronous, rst=0) forces:
  - FSM to IDLE; owner and last_owner to IF.
  - All outputs to 0: mem_en, mem_wr, mem_addr, mem_wdata, if_rdata, dm_rdata, if_done, dm_done, dm_err, stall_cnt.
  - Any in-flight access is abandoned.
- Request seen in IDLE at cycle t:
  - mem_en at t+1.
  - mem_done at cycle k ≥ t+2.
  - done and rdata at k+1.
  - IDLE at k+2.
- Minimum request-to-done latency is 3 cycles; minimum issue interval is 4 cycles.
- A new request may be raised in the cycle after done and is arbitrated in that IDLE cycle.
- Request inputs are sampled only in IDLE. Changes during CMD, WAIT or RESP have no effect on the current access.

## Test plan
- Fetch alone: if_req=1, if_addr=0x0010; mem_done 2 cycles after mem_en with mem_rdata=0xA5A5 -> mem_en pulses at t+1 with mem_wr=0 and mem_addr=0x0010; if_done=1 and if_rdata=0xA5A5 at t+4; if_stall high t..t+3.
- Store: dm_wr=1, dm_addr=0x0200, dm_wdata=0x1234 -> mem_wr=1 with addr/data stable through WAIT; dm_done one cycle after mem_done; dm_rdata unchanged.
- Contention: if_req and dm_rd raised together from reset -> DM is served first (last_owner=IF), then IF; grants keep alternating while both stay asserted.
- Error: dm_rd=dm_wr=1 -> access executes as a write; dm_err=1 and stays high after the request drops, until rst=0.
- Reset mid-WAIT: rst=0 during WAIT, then a late mem_done after release -> all outputs 0; no done pulse; FSM stays in IDLE.
- Counter: hold if_req with mem_done never asserted for 70000 cycles -> stall_cnt reaches 0xFFFF and holds.
